// File: rtl/segre_if_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// segre_if_stage : instruction fetch stage with redirect squash and 2-entry queue
// Rev 1.0
// ----------------------------------------------------------------------------
module segre_if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH  = 2,
  localparam int unsigned WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 hazard_i,
  input  logic                 tkbr_i,
  input  logic [WORD_SIZE-1:0] new_pc_i,
  output logic                 mem_rd_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  input  logic                 mem_ready_i,
  input  logic [WORD_SIZE-1:0] mem_data_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [WORD_SIZE-1:0] pc_o
);

  localparam logic [WORD_SIZE-1:0] NOP     = 32'h0000_0013;
  localparam logic [1:0]           FQ_FULL = 2'(FQ_DEPTH);

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_SQUASH = 2'd2
  } fetch_state_e;

  fetch_state_e         state_q;
  logic [WORD_SIZE-1:0] fpc_q;
  logic [WORD_SIZE-1:0] raddr_q;
  logic [1:0]           cnt_q;
  logic [WORD_SIZE-1:0] fq_pc_q    [2];
  logic [WORD_SIZE-1:0] fq_instr_q [2];
  logic [WORD_SIZE-1:0] instr_q;
  logic [WORD_SIZE-1:0] pc_q;

  logic                 deliver;
  logic                 pop;
  logic                 bypass;
  logic                 push;
  logic                 wr_idx;
  logic [1:0]           cnt_d;
  logic [WORD_SIZE-1:0] fpc_inc;
  logic [1:0]           unused_low_bits;

  // Redirects win over everything, so a response in the same cycle is never delivered.
  assign deliver = (state_q == FETCH_WAIT) && mem_ready_i && !tkbr_i;
  assign pop     = !tkbr_i && !hazard_i && (cnt_q != 2'd0);
  assign bypass  = deliver && !hazard_i && (cnt_q == 2'd0);
  assign push    = deliver && !bypass;
  assign wr_idx  = (cnt_q != 2'd0) && !pop;
  assign cnt_d   = cnt_q - {1'b0, pop} + {1'b0, push};
  assign fpc_inc = fpc_q + 32'd4;

  assign unused_low_bits = new_pc_i[1:0];

  assign mem_rd_o   = (state_q == FETCH_WAIT) || (state_q == FETCH_SQUASH);
  assign mem_addr_o = raddr_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q       <= FETCH_IDLE;
      fpc_q         <= BOOT_ADDR;
      raddr_q       <= BOOT_ADDR;
      cnt_q         <= 2'd0;
      fq_pc_q[0]    <= '0;
      fq_pc_q[1]    <= '0;
      fq_instr_q[0] <= NOP;
      fq_instr_q[1] <= NOP;
      instr_q       <= NOP;
      pc_q          <= '0;
    end else if (tkbr_i) begin
      cnt_q   <= 2'd0;
      fpc_q   <= {new_pc_i[WORD_SIZE-1:2], 2'b00};
      instr_q <= NOP;
      if (state_q != FETCH_IDLE) begin
        state_q <= mem_ready_i ? FETCH_IDLE : FETCH_SQUASH;
      end
    end else begin
      cnt_q <= cnt_d;
      if (pop) begin
        instr_q       <= fq_instr_q[0];
        pc_q          <= fq_pc_q[0];
        fq_instr_q[0] <= fq_instr_q[1];
        fq_pc_q[0]    <= fq_pc_q[1];
      end else if (bypass) begin
        instr_q <= mem_data_i;
        pc_q    <= raddr_q;
      end else if (!hazard_i) begin
        instr_q <= NOP;
      end
      // Placed after the pop shift so a same-cycle push into slot 0 takes effect.
      if (push) begin
        fq_instr_q[wr_idx] <= mem_data_i;
        fq_pc_q[wr_idx]    <= raddr_q;
      end
      case (state_q)
        FETCH_IDLE: begin
          if (cnt_q < FQ_FULL) begin
            state_q <= FETCH_WAIT;
            raddr_q <= fpc_q;
          end
        end
        FETCH_WAIT: begin
          if (mem_ready_i) begin
            fpc_q <= fpc_inc;
            if (cnt_d < FQ_FULL) begin
              raddr_q <= fpc_inc;
            end else begin
              state_q <= FETCH_IDLE;
            end
          end
        end
        FETCH_SQUASH: begin
          if (mem_ready_i) begin
            state_q <= FETCH_IDLE;
          end
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segre_if_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_segre_if_stage : scoreboard bench for the fetch stage against an in-order PC stream model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_segre_if_stage;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        hz  = 1'b0;
  logic        tk  = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        mrd;
  logic [31:0] maddr;
  logic        mrdy  = 1'b0;
  logic [31:0] mdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;

  always #5 clk = ~clk;

  segre_if_stage #(.BOOT_ADDR(BOOT), .FQ_DEPTH(2)) dut (
    .clk_i      (clk),
    .rsn_i      (rsn),
    .hazard_i   (hz),
    .tkbr_i     (tk),
    .new_pc_i   (npc),
    .mem_rd_o   (mrd),
    .mem_addr_o (maddr),
    .mem_ready_i(mrdy),
    .mem_data_i (mdata),
    .instr_o    (instr),
    .pc_o       (pc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Expected program-order PC stream seen by ID; instruction word is pc + 0x100.
  logic [31:0] exp_q [$];
  logic [31:0] exp_next;
  int          mem_mode = 3;   // 0 always ready, 1 random, 2 never, 3 spurious ready

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] target);
    exp_q.delete();
    exp_next = {target[31:2], 2'b00};
    topup();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic redirect(input logic [31:0] target);
    tk  = 1'b1;
    npc = target;
    restart_stream(target);
    cyc();
    tk = 1'b0;
  endtask

  // Instruction memory
  always @(posedge clk) begin
    #2;
    case (mem_mode)
      0: begin mrdy = mrd; mdata = maddr + 32'h100; end
      1: begin mrdy = mrd && ($urandom_range(1, 0) == 1); mdata = maddr + 32'h100; end
      2: begin mrdy = 1'b0; mdata = 32'hBAD0_0000; end
      default: begin mrdy = 1'b1; mdata = 32'hDEAD_0000; end
    endcase
  end

  // Monitor: what ID sees at the coming edge is consumed when not stalled and not redirected.
  logic tk_prev = 1'b0;
  always @(negedge clk) begin
    if (rsn) begin
      if (tk_prev) chk("nop_after_redirect", instr, NOP);
      if (mrd) chk("addr_aligned", {30'd0, maddr[1:0]}, 32'd0);
      if (!tk && instr !== NOP) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h with no expected entry", pc);
        end else begin
          chk("sb_pc", pc, exp_q[0]);
          chk("sb_instr", instr, exp_q[0] + 32'h100);
          if (!hz) void'(exp_q.pop_front());
        end
      end
    end
    tk_prev = tk && rsn;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  to;
    bit  found;
    restart_stream(BOOT);
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_mem_rd", {31'd0, mrd}, 32'd0);
    chk("rst_mem_addr", maddr, BOOT);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'd0);

    // Release with a stray ready pending; the stream must still start cleanly at BOOT.
    cyc();
    rsn = 1'b1;
    cyc();
    mem_mode = 0;
    @(negedge clk);
    chk("first_req_rd", {31'd0, mrd}, 32'd1);
    chk("first_req_addr", maddr, 32'h0);
    cyc(); @(negedge clk); chk("seq_addr_4", maddr, 32'h4);
    cyc(); @(negedge clk); chk("seq_addr_8", maddr, 32'h8);
    repeat (4) begin
      cyc(); @(negedge clk);
      chk("stream_no_nop", 32'(instr == NOP), 32'd0);
    end

    // Three-cycle stall: queue fills and requests stop.
    hz = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("stall_rd_drops", {31'd0, mrd}, 32'd0);
    hz = 1'b0;
    repeat (6) cyc();

    // Redirect coinciding with a response.
    @(negedge clk);
    chk("pre_same_cycle_wait", {31'd0, mrd}, 32'd1);
    redirect(32'h80);
    @(negedge clk);
    chk("same_cycle_rd", {31'd0, mrd}, 32'd0);
    chk("same_cycle_nop", instr, NOP);
    cyc(); @(negedge clk);
    chk("same_cycle_next_addr", maddr, 32'h80);
    repeat (3) cyc();

    // Redirect while the request to 0x10 is outstanding.
    redirect(32'h0);
    to = 0;
    found = 0;
    while (!found && to < 50) begin
      cyc();
      if (mrd && maddr == 32'h10) begin
        mem_mode = 2;
        found = 1;
      end
      to++;
    end
    chk("wait_req_0x10", {31'd0, found}, 32'd1);
    cyc(); cyc();
    redirect(32'h42);
    mem_mode = 0;
    @(negedge clk);
    chk("squash_rd", {31'd0, mrd}, 32'd1);
    chk("squash_addr_held", maddr, 32'h10);
    chk("squash_nop", instr, NOP);
    cyc(); @(negedge clk);
    chk("squash_idle_rd", {31'd0, mrd}, 32'd0);
    chk("squash_idle_nop", instr, NOP);
    cyc(); @(negedge clk);
    chk("squash_next_addr", maddr, 32'h40);
    chk("squash_next_rd", {31'd0, mrd}, 32'd1);
    repeat (4) cyc();

    // PC wrap.
    redirect(32'hFFFF_FFF4);
    to = 0;
    found = 0;
    while (!found && to < 20) begin
      cyc(); @(negedge clk);
      if (pc == 32'hFFFF_FFFC && instr != NOP) found = 1;
      to++;
    end
    chk("wrap_reached_fffffffc", {31'd0, found}, 32'd1);
    cyc(); @(negedge clk);
    chk("wrap_pc_zero", pc, 32'h0);
    repeat (3) cyc();

    // Reset mid-request under stall.
    mem_mode = 2;
    hz = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("pre_reset_wait", {31'd0, mrd}, 32'd1);
    cyc();
    rsn = 1'b0;
    mem_mode = 3;
    restart_stream(BOOT);
    #1;
    chk("async_rst_rd", {31'd0, mrd}, 32'd0);
    chk("async_rst_addr", maddr, BOOT);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_pc", pc, 32'd0);
    hz = 1'b0;
    cyc(); cyc();
    rsn = 1'b1;
    cyc();
    mem_mode = 0;
    @(negedge clk);
    chk("post_rst_addr", maddr, BOOT);
    chk("post_rst_rd", {31'd0, mrd}, 32'd1);

    // Randomized traffic.
    mem_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      hz = ($urandom_range(99, 0) < 30);
      if ($urandom_range(99, 0) < 4) begin
        tk  = 1'b1;
        npc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                           : $urandom;
        restart_stream(npc);
      end else begin
        tk = 1'b0;
      end
      if (i == 700) begin
        rsn = 1'b0;
        tk  = 1'b0;
        restart_stream(BOOT);
        cyc();
        rsn = 1'b1;
      end
    end
    tk = 1'b0;
    hz = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
